// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 target receiver for fixed 16-bit frames.
//
// A frame is one ncs-low window. Bits arrive MSB first on copi and are sampled
// on sclk rising edges. The frame layout is {rw, addr[6:0], data[7:0]}.
// Exactly 16 sclk rising edges inside the window produce a frame_valid pulse
// carrying the decoded fields. Any other edge count produces a frame_err pulse
// and leaves the fields untouched.
//
// Ports
//   clk          system clock; all state updates on its rising edge
//   rst_n        synchronous active-low reset
//   sclk         raw SPI clock (asynchronous to clk)
//   copi         raw SPI data from the controller (asynchronous)
//   ncs          raw active-low chip select (asynchronous)
//   frame_valid  one-cycle pulse: a good 16-bit frame was received
//   frame_rw     frame bit 15 (1 = write), held until the next frame_valid
//   frame_addr   frame bits 14:8, held until the next frame_valid
//   frame_data   frame bits 7:0, held until the next frame_valid
//   frame_err    one-cycle pulse: malformed frame (edge count != 16)
//   busy         high while a frame is in progress
//
// Timing: frame_valid/frame_err rise SYNC_STAGES+2 clk cycles after the first
// clk edge that samples raw ncs high. sclk must be slower than clk/4.
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       frame_valid,
  output logic       frame_rw,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Idle bus pattern: sclk low, copi low, chip deselected.
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    end
  end

  logic sclk_s;
  logic copi_s;
  logic ncs_s;

  always_comb begin
    sclk_s = sclk_sync_q[SYNC_STAGES-1];
    copi_s = copi_sync_q[SYNC_STAGES-1];
    ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  end

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  logic       sclk_prev_q;
  logic       ncs_prev_q;
  logic [1:0] flush_q;
  logic       armed_q;
  logic       flushed;

  logic       sclk_rise_d;
  logic       ncs_rise_d;
  logic       ncs_fall_d;

  logic       sclk_rise_q;
  logic       ncs_rise_q;
  logic       ncs_fall_q;
  logic       copi_q;

  // The synchronizers reset to ncs-high, so a chip select that is already low
  // at reset release would look like a falling edge once the chain refills.
  // Falling edges are only honoured after ncs has been seen high on a value
  // that genuinely came from the pin (chain fully refilled since reset).
  always_comb begin
    flushed     = (flush_q == 2'(SYNC_STAGES));
    sclk_rise_d = sclk_s & ~sclk_prev_q;
    ncs_rise_d  = ncs_s & ~ncs_prev_q;
    ncs_fall_d  = ~ncs_s & ncs_prev_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      sclk_rise_q <= 1'b0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
      copi_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      if (!flushed) begin
        flush_q <= flush_q + 2'd1;
      end
      armed_q     <= armed_q | (flushed & ncs_s);
      // Edge flags and the data bit are registered together so an sclk edge
      // and an ncs edge that coincide in the synchronized domain stay
      // coincident at the FSM.
      sclk_rise_q <= sclk_rise_d;
      ncs_rise_q  <= ncs_rise_d;
      ncs_fall_q  <= ncs_fall_d;
      copi_q      <= copi_s;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [15:0] shift_q;
  logic [4:0]  cnt_q;
  logic        valid_pend_q;
  logic        err_pend_q;
  logic        frame_valid_q;
  logic        frame_err_q;
  logic        frame_rw_q;
  logic [6:0]  frame_addr_q;
  logic [7:0]  frame_data_q;
  logic        busy_q;

  // The completion verdict is decided on the ACTIVE->IDLE edge and issued one
  // cycle later. The shift register is only cleared by a later frame start,
  // and that clear is non-blocking, so a new frame starting in the pulse
  // cycle cannot corrupt the fields being presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      valid_pend_q  <= 1'b0;
      err_pend_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_rw_q    <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= valid_pend_q;
      frame_err_q   <= err_pend_q;
      if (valid_pend_q) begin
        frame_rw_q   <= shift_q[15];
        frame_addr_q <= shift_q[14:8];
        frame_data_q <= shift_q[7:0];
      end
      valid_pend_q <= 1'b0;
      err_pend_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ncs_fall_q) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        ACTIVE: begin
          if (ncs_rise_q) begin
            // An sclk edge coinciding with deselect is deliberately dropped.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (cnt_q == 5'd16) begin
              valid_pend_q <= 1'b1;
            end else begin
              err_pend_q <= 1'b1;
            end
          end else if (sclk_rise_q) begin
            shift_q <= {shift_q[14:0], copi_q};
            if (cnt_q != 5'd17) begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    frame_valid = frame_valid_q;
    frame_err   = frame_err_q;
    frame_rw    = frame_rw_q;
    frame_addr  = frame_addr_q;
    frame_data  = frame_data_q;
    busy        = busy_q;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (legal values 2..3) on the sclk, copi and ncs inputs.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port sclk, input, 1 bit: raw SPI clock, asynchronous to clk.
REQ-005 SHALL have port copi, input, 1 bit: raw SPI data from controller, asynchronous.
REQ-006 SHALL have port ncs, input, 1 bit: raw active-low chip select, asynchronous.
REQ-007 SHALL have port frame_valid, output, 1 bit: one-cycle pulse marking a good 16-bit frame.
REQ-008 SHALL have port frame_rw, output, 1 bit: frame bit 15 (1 = write).
REQ-009 SHALL have port frame_addr, output, 7 bits: frame bits 14:8.
REQ-010 SHALL have port frame_data, output, 8 bits: frame bits 7:0.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a malformed frame.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress (state ACTIVE).

Function
REQ-013 SHALL pass each of sclk, copi and ncs through its own SYNC_STAGES-deep flip-flop chain; all logic downstream of the chains SHALL use only the synchronized values.
REQ-014 SHALL detect an sclk rising edge as synchronized sclk = 1 while its previous-cycle value = 0; ncs falling and rising edges SHALL be detected the same way.
REQ-015 SHALL operate in SPI mode 0 only: copi is sampled on each sclk rising edge, MSB first, into a 16-bit shift register.
REQ-016 SHALL use a two-state FSM:
  - IDLE -> ACTIVE on a synchronized ncs falling edge; the shift register and the 5-bit edge counter clear in the same cycle.
  - ACTIVE -> IDLE on a synchronized ncs rising edge.
REQ-017 SHALL ignore sclk edges in IDLE.
REQ-018 In ACTIVE, each sclk rising edge SHALL shift in copi and increment the counter; the counter SHALL saturate at 17.
REQ-019 SHALL ignore any sclk rising edge detected in the same cycle as the ncs rising edge: no shift, no count.
REQ-020 On the ACTIVE->IDLE transition with counter = 16, SHALL assert frame_valid for exactly the next clk cycle and, in that same cycle, present the shift register on frame_rw, frame_addr and frame_data.
REQ-021 On the ACTIVE->IDLE transition with counter != 16 (short, empty or over-long frame), SHALL assert frame_err for exactly the next clk cycle, leave frame_rw/addr/data unchanged and never assert frame_valid.
REQ-022 frame_rw, frame_addr and frame_data SHALL hold their values until the next frame_valid.
REQ-023 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-024 Back-to-back frames SHALL be accepted when ncs is high for at least one synchronized clk cycle between them.
REQ-025 A synchronized ncs falling edge in the cycle right after a frame completes SHALL start a new frame while the pulse for the previous frame is issued.
REQ-026 Latency: frame_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples raw ncs high; SYNC_STAGES+2 = 4 at the default.
REQ-027 sclk shall be slower than clk/4 for correct operation; behaviour above that rate is unspecified.

Reset
REQ-028 While rst_n = 0 at a clk edge, the following SHALL be cleared: FSM to IDLE, shift register = 0, counter = 0, frame_valid = 0, frame_err = 0, frame_rw = 0, frame_addr = 0, frame_data = 0, busy = 0.
REQ-029 All synchronizer flops SHALL reset to the ncs-idle pattern: sclk = 0, copi = 0, ncs = 1.
REQ-030 A reset asserted mid-frame SHALL discard the partial frame and produce neither frame_valid nor frame_err.
REQ-031 After reset release with ncs already low, no frame SHALL start until a fresh ncs falling edge is seen.

Verification
REQ-032 SHALL cover: send word 0x80F0 with sclk = clk/8 -> one frame_valid pulse with rw = 1, addr = 0x00, data = 0xF0, raised 4 cycles after raw ncs rises.
REQ-033 SHALL cover: send 0x0455 then, after a 2-cycle ncs gap, 0x8A3C -> two valid pulses, giving (0, 0x04, 0x55) then (1, 0x0A, 0x3C).
REQ-034 SHALL cover: a 12-bit frame, then a 17-bit frame -> two frame_err pulses, no frame_valid, and outputs keep the prior values.
REQ-035 SHALL cover: ncs low and high with no sclk edges -> one frame_err pulse.
REQ-036 SHALL cover: rst_n pulsed low after 9 bits, then ncs released -> no valid and no err, all outputs 0, busy = 0.
REQ-037 SHALL cover: a 16th sclk rising edge that coincides with the ncs rising edge -> counter = 15 -> frame_err.
